stream_decipher: RTL and testbench
==================================

STREAM_DECIPHER -- requirements
Module: stream_decipher

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the cipher/plain byte width.
REQ-002 The module SHALL have parameter LFSR_W, default 16, giving the keystream LFSR width.
REQ-003 The module SHALL have parameter TAPS, default 16'hB400, giving the Galois feedback mask.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The module SHALL have port load_key, input, 1 bit: a one-cycle pulse that loads the key.
REQ-007 The module SHALL have port key, input, LFSR_W bits: the seed, sampled when load_key=1.
REQ-008 The module SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_W): the cipher byte stream.
REQ-009 The module SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, DATA_W): the plain byte stream.
REQ-010 The module SHALL have port key_err, output, 1 bit: sticky flag, set when a zero key is loaded.

Function
REQ-011 The FSM SHALL have states IDLE (unkeyed) and RUN (keyed).
- load_key with key≠0: go to RUN, state←key, key_err←0.
- load_key with key=0: go to IDLE, key_err←1.
REQ-012 load_key SHALL take priority over every other event in its cycle.
- out_valid←0.
- Any simultaneous in_valid byte is not accepted.
REQ-013 in_ready SHALL equal (state==RUN) && !load_key && (!out_valid || out_ready), as a combinational function.
REQ-014 An input transfer (in_valid && in_ready) SHALL, at the next edge:
- set out_data←in_data ^ lfsr[DATA_W-1:0];
- set out_valid←1;
- advance the LFSR by exactly DATA_W Galois steps.
REQ-015 A Galois step SHALL be: b=s[0]; s=s>>1; if b then s=s^TAPS.
REQ-016 Latency SHALL be one cycle, and throughput one byte per cycle while out_ready=1.
REQ-017 While out_valid=1 and out_ready=0, out_data SHALL be held stable and in_ready SHALL be 0.
REQ-018 When out_ready=1 and there is no new input transfer, out_valid SHALL clear at the next edge.
REQ-019 The LFSR SHALL advance only on input transfers; stalls and IDLE cycles SHALL NOT advance it.
REQ-020 In IDLE, in_ready SHALL be 0 and out_valid SHALL be 0.

Reset
REQ-021 rst=1 at a clock edge SHALL force:
- state IDLE, LFSR 0, out_valid 0, out_data 0, key_err 0;
- byte_cnt 0 where present.
REQ-022 rst SHALL override load_key and any transfer in the same cycle, and a byte held mid-stall SHALL be discarded.

Configuration
REQ-023 With DECIPHER_CNT_EN defined, the module SHALL add output port byte_cnt[15:0].
- Increments on each input transfer.
- Wraps 16'hFFFF→0.
- Cleared by rst and by load_key.
REQ-024 With DECIPHER_CNT_EN undefined, the byte_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Package stream_cypher_pkg SHALL hold:
- the DATA_W and LFSR_W defaults;
- DEFAULT_TAPS (16'hB400);
- the FSM state enum type.
REQ-026 The keystream generator SHALL be sub-module keystream_lfsr, with:
- inputs clk, rst, load, seed, advance;
- output state;
- combinational 8-step unrolled next-state logic.
REQ-027 Handshake, FSM and output register logic SHALL reside in stream_decipher.

Verification
REQ-028 Key load and first byte: rst, load_key with key=16'h0001, then in_data=8'h41 accepted → next cycle out_data=8'h40, out_valid=1.
REQ-029 Keystream advance: a second byte in_data=8'h68 accepted back-to-back → out_data=8'h00, and LFSR=16'h0168 before that transfer.
REQ-030 Output stall: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_data stable, LFSR unchanged; then out_ready=1 → the stream resumes with no loss or duplication.
REQ-031 Zero key: load_key with key=0 → key_err=1, in_ready=0; then load_key with key=16'h0001 → key_err=0, RUN.
REQ-032 Rekey mid-stream: load_key with key=16'h0001 asserted with in_valid=1 while out_valid=1 → the byte is not accepted, out_valid=0 next cycle, and the next byte 8'h41 → 8'h40.
REQ-033 Counter (DECIPHER_CNT_EN): 65537 transfers after a key load → byte_cnt=1; rst mid-stream → byte_cnt=0 and out_valid=0.

Source files
------------

// File: rtl/stream_cypher_pkg.sv
// Shared defaults and FSM state type for the stream decipher.
// Optional byte counter is enabled by defining DECIPHER_CNT_EN.
package stream_cypher_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_LFSR_W = 16;
   localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } dec_state_e;

endpackage

// File: rtl/stream_decipher_keystream_lfsr.sv
// Galois LFSR keystream generator; advances DATA_W steps per request
// through an unrolled combinational next-state chain.
module keystream_lfsr
   import stream_cypher_pkg::*;
#(
   parameter int LFSR_W = DEFAULT_LFSR_W,
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter logic [LFSR_W-1:0] TAPS = LFSR_W'(DEFAULT_TAPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              advance,
   output logic [LFSR_W-1:0] state
);

   logic [LFSR_W-1:0] nxt;

   function automatic logic [LFSR_W-1:0] gstep(
      input logic [LFSR_W-1:0] s
   );
      gstep = (s >> 1) ^ (s[0] ? TAPS : '0);
   endfunction

   always_comb begin
      nxt = state;
      for (int i = 0; i < DATA_W; i++) begin
         nxt = gstep(nxt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= '0;
      end else if (load) begin
         state <= seed;
      end else if (advance) begin
         state <= nxt;
      end
   end

endmodule

// File: rtl/stream_decipher.sv
// Keyed stream decipher: XORs cipher bytes with an LFSR keystream.
// Define DECIPHER_CNT_EN to add the byte_cnt transfer counter port.
module stream_decipher
   import stream_cypher_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int LFSR_W = DEFAULT_LFSR_W,
   parameter logic [LFSR_W-1:0] TAPS = LFSR_W'(DEFAULT_TAPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_key,
   input  logic [LFSR_W-1:0] key,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              key_err
`ifdef DECIPHER_CNT_EN
   ,
   output logic [15:0]       byte_cnt
`endif
);

   dec_state_e        state;
   logic [LFSR_W-1:0] lfsr;
   logic              xfer;
   logic              key_ok;

   assign key_ok = (key != '0);

   assign in_ready = (state == ST_RUN) && !load_key
                   && (!out_valid || out_ready);

   assign xfer = in_valid && in_ready;

   // A zero seed would lock the LFSR, so it is never loaded.
   keystream_lfsr #(
      .LFSR_W (LFSR_W),
      .DATA_W (DATA_W),
      .TAPS   (TAPS)
   ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (load_key && key_ok),
      .seed    (key),
      .advance (xfer),
      .state   (lfsr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         key_err   <= 1'b0;
      end else if (load_key) begin
         out_valid <= 1'b0;
         if (key_ok) begin
            state   <= ST_RUN;
            key_err <= 1'b0;
         end else begin
            state   <= ST_IDLE;
            key_err <= 1'b1;
         end
      end else if (xfer) begin
         out_data  <= in_data ^ lfsr[DATA_W-1:0];
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef DECIPHER_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || load_key) begin
         byte_cnt <= '0;
      end else if (xfer) begin
         byte_cnt <= byte_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_stream_decipher.sv
// Scoreboard bench for stream_decipher with hand-computed keystream
// bytes for key 16'h0001: 01, 68, 41, 14, 7B.
module tb_stream_decipher;

   logic        clk;
   logic        rst;
   logic        load_key;
   logic [15:0] key;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        key_err;
`ifdef DECIPHER_CNT_EN
   logic [15:0] byte_cnt;
`endif

   int          checks;
   int          failures;
   logic [7:0]  sb[$];
   logic [7:0]  exp_cur;
   logic        cnt_mode;

   stream_decipher dut (
      .clk       (clk),
      .rst       (rst),
      .load_key  (load_key),
      .key       (key),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .key_err   (key_err)
`ifdef DECIPHER_CNT_EN
      ,
      .byte_cnt  (byte_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] e);
      logic acc;
      acc = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      exp_cur  = e;
      for (int n = 0; n < 50 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
         tick();
      end
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
   endtask

   // expected output recorded at the moment an input transfer occurs
   always @(negedge clk) begin
      if (!rst && !cnt_mode && in_valid && in_ready)
         sb.push_back(exp_cur);
   end

   always @(negedge clk) begin
      if (!rst && !cnt_mode && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected: got %0h expected none",
                     out_data);
         end else begin
            logic [7:0] e;
            e = sb.pop_front();
            if (out_data !== e) begin
               failures++;
               $display("FAIL out_data: got %0h expected %0h",
                        out_data, e);
            end
         end
      end
   end

   initial begin
      checks    = 0;
      failures  = 0;
      cnt_mode  = 1'b0;
      rst       = 1'b1;
      load_key  = 1'b0;
      key       = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      exp_cur   = '0;
      out_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_key_err", 32'(key_err), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      tick();
      rst = 1'b0;

      load_key = 1'b1;
      key      = 16'h0001;
      in_valid = 1'b1;
      in_data  = 8'h99;
      @(negedge clk);
      chk("load_blocks_in", 32'(in_ready), 32'd0);
      tick();
      load_key = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("run_in_ready", 32'(in_ready), 32'd1);
      chk("seed_lfsr", 32'(dut.u_lfsr.state), 32'h0001);
      tick();

      send(8'h41, 8'h40);
      @(negedge clk);
      chk("first_out_valid", 32'(out_valid), 32'd1);
      chk("lfsr_before_2nd", 32'(dut.u_lfsr.state), 32'h0168);
      tick();
      send(8'h68, 8'h00);

      // stall with a byte pending
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hA5;
      exp_cur   = 8'hE4;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_data", 32'(out_data), 32'h00);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_lfsr", 32'(dut.u_lfsr.state), 32'h7C41);
         tick();
      end
      out_ready = 1'b1;
      send(8'hA5, 8'hE4);
      send(8'h3C, 8'h28);
      send(8'hFF, 8'h84);
      tick();
      @(negedge clk);
      chk("drain_out_valid", 32'(out_valid), 32'd0);
      chk("sb_empty_1", 32'(sb.size()), 32'd0);
      tick();

      // zero key
      load_key = 1'b1;
      key      = 16'h0000;
      tick();
      load_key = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h12;
      @(negedge clk);
      chk("zero_key_err", 32'(key_err), 32'd1);
      chk("zero_in_ready", 32'(in_ready), 32'd0);
      chk("zero_out_valid", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      load_key = 1'b1;
      key      = 16'h0001;
      tick();
      load_key = 1'b0;
      @(negedge clk);
      chk("rekey_err_clr", 32'(key_err), 32'd0);
      chk("rekey_in_ready", 32'(in_ready), 32'd1);
      tick();

      // rekey while an output is pending
      send(8'h41, 8'h40);
      out_ready = 1'b0;
      load_key  = 1'b1;
      key       = 16'h0001;
      in_valid  = 1'b1;
      in_data   = 8'h55;
      exp_cur   = 8'hEE;
      @(negedge clk);
      chk("mid_rekey_in_ready", 32'(in_ready), 32'd0);
      tick();
      load_key = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("mid_rekey_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rekey_sb", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
      tick();
      out_ready = 1'b1;
      send(8'h41, 8'h40);
      send(8'h68, 8'h00);

      // reset discards a stalled byte
      out_ready = 1'b0;
      tick();
      rst = 1'b1;
      sb.delete();
      tick();
      @(negedge clk);
      chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_out_data", 32'(out_data), 32'd0);
      chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
      chk("rst_mid_lfsr", 32'(dut.u_lfsr.state), 32'd0);
      tick();
      rst       = 1'b0;
      out_ready = 1'b1;
      tick();

`ifdef DECIPHER_CNT_EN
      cnt_mode = 1'b1;
      load_key = 1'b1;
      key      = 16'h0001;
      tick();
      load_key = 1'b0;
      @(negedge clk);
      chk("cnt_after_load", 32'(byte_cnt), 32'd0);
      tick();
      in_valid = 1'b1;
      repeat (65537) tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("cnt_wrap", 32'(byte_cnt), 32'd1);
      tick();
      in_valid = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("cnt_rst", 32'(byte_cnt), 32'd0);
      chk("cnt_rst_out_valid", 32'(out_valid), 32'd0);
      tick();
      cnt_mode = 1'b0;
`endif

      for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
      chk("sb_final_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
